// File: rtl/tdc_measure_ctrl.sv
// TDC measurement sequencer: arm, capture start bin, count coarse cycles, capture stop bin, hand off timestamp.
// Optional ARMED timeout is enabled by defining TDC_TIMEOUT_EN.
module tdc_measure_ctrl #(
  parameter int BITS_DECO   = 8,
  parameter int NUM_BINS    = 200,
  parameter int COARSE_W    = 12,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                          wClk,
  input  logic                          wRstN,
  input  logic                          wArm,
  input  logic                          wAbort,
  input  logic [BITS_DECO-1:0]          wDecoStartIn,
  input  logic [BITS_DECO-1:0]          wDecoStopIn,
  output logic                          wBusy,
  output logic                          wValid,
  input  logic                          wReady,
  output logic [BITS_DECO-1:0]          wStartBin,
  output logic [BITS_DECO-1:0]          wStopBin,
  output logic [COARSE_W-1:0]           wCoarse,
  output logic [COARSE_W+BITS_DECO:0]   wTime,
  output logic                          wOverflow,
  output logic                          wTimeout
);

  localparam int TIME_W = COARSE_W + BITS_DECO + 1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;

  state_t              state;
  logic [COARSE_W-1:0] coarse_cnt;
  logic                start_hit;
  logic                stop_hit;

  // Unsigned timestamp; bins above NUM_BINS simply wrap modulo 2^TIME_W.
  function automatic logic [TIME_W-1:0] calc_time(
    input logic [COARSE_W-1:0]  coarse,
    input logic [BITS_DECO-1:0] start_bin,
    input logic [BITS_DECO-1:0] stop_bin
  );
    logic [TIME_W-1:0] scaled;
    scaled = TIME_W'(coarse) * TIME_W'(NUM_BINS);
    return scaled + TIME_W'(start_bin) - TIME_W'(stop_bin);
  endfunction

  assign start_hit = (wDecoStartIn != '0);
  assign stop_hit  = (wDecoStopIn != '0);
  assign wBusy     = (state != IDLE);

`ifdef TDC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  assign wTimeout = timeout_q;
`else
  // TIMEOUT_CYC only matters in the timeout build.
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign wTimeout           = 1'b0;
`endif

  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      state      <= IDLE;
      coarse_cnt <= '0;
      wValid     <= 1'b0;
      wStartBin  <= '0;
      wStopBin   <= '0;
      wCoarse    <= '0;
      wTime      <= '0;
      wOverflow  <= 1'b0;
`ifdef TDC_TIMEOUT_EN
      to_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef TDC_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      if (wAbort) begin
        state     <= IDLE;
        wValid    <= 1'b0;
        wOverflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wArm) begin
              state <= ARMED;
`ifdef TDC_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
          ARMED: begin
            // A stop arriving together with the start is dropped here.
            if (start_hit) begin
              state      <= RUNNING;
              wStartBin  <= wDecoStartIn;
              coarse_cnt <= COARSE_W'(1);
            end
`ifdef TDC_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              state     <= IDLE;
              timeout_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
          RUNNING: begin
            if (stop_hit) begin
              state    <= DONE;
              wValid   <= 1'b1;
              wStopBin <= wDecoStopIn;
              wCoarse  <= coarse_cnt;
              wTime    <= calc_time(coarse_cnt, wStartBin, wDecoStopIn);
            end else if (coarse_cnt == COARSE_MAX) begin
              state     <= DONE;
              wValid    <= 1'b1;
              wOverflow <= 1'b1;
              wStopBin  <= '0;
              wCoarse   <= coarse_cnt;
              wTime     <= calc_time(coarse_cnt, wStartBin, '0);
            end else begin
              coarse_cnt <= coarse_cnt + COARSE_W'(1);
            end
          end
          DONE: begin
            if (wReady) begin
              wValid    <= 1'b0;
              wOverflow <= 1'b0;
              state     <= wArm ? ARMED : IDLE;
`ifdef TDC_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
